// File: rtl/io_pkg.sv
// Shared field layout of the core's IO window buses and a small helper for
// locating a digit's segment byte inside the output bus.
package io_pkg;

    // Input bus layout: switches in the low bits, buttons above them.
    localparam int SW_LSB  = 0;
    localparam int SW_MSB  = 9;
    localparam int BTN_LSB = 10;
    localparam int BTN_MSB = 13;

    // Output bus layout: one segment byte per digit, LEDs on top.
    localparam int LED_LSB = 48;
    localparam int LED_MSB = 51;
    localparam int SEG_W   = 8;

    localparam int DEF_NUM_DIGITS = 6;

    // Bit position of the lowest segment bit of digit idx.
    function automatic int unsigned digit_base(input int unsigned idx);
        return idx * 32'(SEG_W);
    endfunction

endpackage : io_pkg

// File: rtl/io_debounce.sv
// One input channel: two-flop synchroniser followed by a stability counter.
// A new level is accepted only after it has been seen on the synchronised
// signal for DEBOUNCE_CYCLES consecutive edges; any bounce back restarts it.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the pin and accept a change once it has held long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign clean = stable_r;

endmodule : io_debounce

// File: rtl/io_board_bridge.sv
// Board-side bridge for the core's IO window: debounced switches/buttons
// towards the core, and a tear-free multiplexed seven-segment display plus
// LEDs from the core's output bus.
module io_board_bridge
    import io_pkg::*;
#(
    parameter int IO_INPUT_BUS_LEN  = 14,
    parameter int IO_OUTPUT_BUS_LEN = 52,
    parameter int NUM_DIGITS        = DEF_NUM_DIGITS,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int SCAN_CYCLES       = 50000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [9:0]                   sw_raw,
    input  logic [3:0]                   btn_n_raw,
    input  logic [IO_OUTPUT_BUS_LEN-1:0] io_output_bus,
    output logic [IO_INPUT_BUS_LEN-1:0]  io_input_bus,
    output logic [7:0]                   seg_n,
    output logic [NUM_DIGITS-1:0]        digit_sel_n,
    output logic [3:0]                   led
);

    localparam int FRAME_W = NUM_DIGITS * SEG_W;
    localparam int SCAN_W  = $clog2(SCAN_CYCLES);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    // ---------------- input path ----------------
    logic [IO_INPUT_BUS_LEN-1:0] raw_s;

    // Buttons are active-low on the board; present everything as 1 = pressed.
    assign raw_s[SW_MSB:SW_LSB]   = sw_raw;
    assign raw_s[BTN_MSB:BTN_LSB] = ~btn_n_raw;

    for (genvar gi = 0; gi < IO_INPUT_BUS_LEN; gi++) begin : g_debounce
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (raw_s[gi]),
            .clean(io_input_bus[gi])
        );
    end

    // ---------------- display path ----------------
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [IDX_W-1:0]   digit_idx_r;
    logic [FRAME_W-1:0] frame_r;
    logic               load_pending_r;

    logic [SCAN_W-1:0]  scan_next_s;
    logic [IDX_W-1:0]   idx_next_s;
    logic               frame_wrap_s;
    logic [FRAME_W-1:0] frame_next_s;
    logic [SEG_W-1:0]   seg_on_s;

    // Next scan position, next frame contents and the segments that go with
    // them; segments come from the post-load frame so digit 0 of a new frame
    // never shows stale data.
    always_comb begin
        scan_next_s  = '0;
        idx_next_s   = digit_idx_r;
        frame_wrap_s = 1'b0;
        if (scan_cnt_r == SCAN_LAST) begin
            scan_next_s = '0;
            if (digit_idx_r == IDX_LAST) begin
                idx_next_s   = '0;
                frame_wrap_s = 1'b1;
            end else begin
                idx_next_s   = digit_idx_r + IDX_W'(1);
                frame_wrap_s = 1'b0;
            end
        end else begin
            scan_next_s  = scan_cnt_r + SCAN_W'(1);
            idx_next_s   = digit_idx_r;
            frame_wrap_s = 1'b0;
        end

        if (frame_wrap_s || load_pending_r) begin
            frame_next_s = io_output_bus[FRAME_W-1:0];
        end else begin
            frame_next_s = frame_r;
        end

        seg_on_s = frame_next_s[digit_base(32'(idx_next_s)) +: SEG_W];
    end

    // Scan state, frame shadow and registered display/LED pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_r     <= '0;
            digit_idx_r    <= '0;
            frame_r        <= '0;
            load_pending_r <= 1'b1;
            seg_n          <= 8'hFF;
            digit_sel_n    <= ~SEL_ONE;
            led            <= 4'b0000;
        end else begin
            scan_cnt_r     <= scan_next_s;
            digit_idx_r    <= idx_next_s;
            frame_r        <= frame_next_s;
            load_pending_r <= 1'b0;
            seg_n          <= ~seg_on_s;
            digit_sel_n    <= ~(SEL_ONE << idx_next_s);
            led            <= io_output_bus[LED_MSB:LED_LSB];
        end
    end

endmodule : io_board_bridge

// File: tb/tb_io_board_bridge.sv
// Self-checking bench for io_board_bridge with short debounce/scan periods.
module tb_io_board_bridge;

    localparam int D  = 4;
    localparam int SC = 3;
    localparam int ND = 6;
    localparam logic [47:0] PATTERN = 48'h3F_06_5B_4F_66_6D;

    logic        clk;
    logic        reset;
    logic [9:0]  sw_raw;
    logic [3:0]  btn_n_raw;
    logic [51:0] io_output_bus;
    logic [13:0] io_input_bus;
    logic [7:0]  seg_n;
    logic [5:0]  digit_sel_n;
    logic [3:0]  led;

    int errors = 0;
    int checks = 0;

    io_board_bridge #(
        .IO_INPUT_BUS_LEN (14),
        .IO_OUTPUT_BUS_LEN(52),
        .NUM_DIGITS       (ND),
        .DEBOUNCE_CYCLES  (D),
        .SCAN_CYCLES      (SC)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .btn_n_raw    (btn_n_raw),
        .io_output_bus(io_output_bus),
        .io_input_bus (io_input_bus),
        .seg_n        (seg_n),
        .digit_sel_n  (digit_sel_n),
        .led          (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Inputs: a level is accepted when the synchronised value (raw delayed
    // two edges) has differed from the accepted level for the last D edges.
    // Display: edge count since reset gives the scan position directly.
    logic [13:0] m_hist [0:D];
    logic [13:0] m_in;
    int          m_n;
    logic [47:0] m_frame;
    logic [7:0]  exp_seg;
    logic [5:0]  exp_sel;
    logic [3:0]  exp_led;
    logic [13:0] raw_now;

    assign raw_now = {~btn_n_raw, sw_raw};

    function automatic logic [13:0] debounce_next();
        logic [13:0] r;
        logic        all_flip;
        r = m_in;
        for (int b = 0; b < 14; b++) begin
            all_flip = 1'b1;
            for (int j = 1; j <= D; j++)
                if (m_hist[j][b] == m_in[b]) all_flip = 1'b0;
            if (all_flip) r[b] = ~m_in[b];
        end
        return r;
    endfunction

    function automatic logic [47:0] frame_after(int nn, logic [47:0] fr, logic [51:0] bus);
        if (nn == 1 || nn % (SC * ND) == 0) return bus[47:0];
        return fr;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j <= D; j++) m_hist[j] <= '0;
            m_in    <= '0;
            m_n     <= 0;
            m_frame <= '0;
            exp_seg <= 8'hFF;
            exp_sel <= 6'b111110;
            exp_led <= 4'h0;
        end else begin
            m_hist[0] <= raw_now;
            for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
            m_in    <= debounce_next();
            m_n     <= m_n + 1;
            m_frame <= frame_after(m_n + 1, m_frame, io_output_bus);
            exp_seg <= ~(frame_after(m_n + 1, m_frame, io_output_bus) >> (8 * (((m_n + 1) / SC) % ND)));
            exp_sel <= ~(6'b000001 << (((m_n + 1) / SC) % ND));
            exp_led <= io_output_bus[51:48];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic [51:0] bus);
        io_output_bus = bus;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        io_output_bus = {4'h0, PATTERN};
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({io_input_bus, seg_n, digit_sel_n, led} !== {14'h0000, 8'hFF, 6'b111110, 4'h0}) begin
            errors++;
            $display("FAIL reset_values: in=%h seg=%h sel=%b led=%h, want 0000 ff 111110 0",
                     io_input_bus, seg_n, digit_sel_n, led);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (seg_n !== 8'h92 || digit_sel_n !== 6'b111110) begin
            errors++;
            $display("FAIL first_frame_load: seg=%h sel=%b, want 92 111110", seg_n, digit_sel_n);
        end
    endtask

    task automatic test_scan();
        logic [7:0] tbl [0:5];
        int idx;
        tbl = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        do_reset({4'h0, PATTERN});
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            idx = (n / SC) % ND;
            checks++;
            if (seg_n !== tbl[idx] || digit_sel_n !== ~(6'b000001 << idx)) begin
                errors++;
                $display("FAIL scan n=%0d: seg=%h sel=%b, want %h %b",
                         n, seg_n, digit_sel_n, tbl[idx], ~(6'b000001 << idx));
            end
        end
    endtask

    task automatic test_tear_free();
        do_reset({4'h0, PATTERN});
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 6) io_output_bus[47:40] = 8'hFF;
            if ((n / SC) % ND == 5) begin
                checks++;
                if (seg_n !== ((n < 18) ? 8'hC0 : 8'h00)) begin
                    errors++;
                    $display("FAIL tear_free n=%0d: seg=%h, want %h", n, seg_n, (n < 18) ? 8'hC0 : 8'h00);
                end
            end
            checks++;
            if ({seg_n, digit_sel_n} !== {exp_seg, exp_sel}) begin
                errors++;
                $display("FAIL tear_free_model n=%0d: seg=%h sel=%b, want %h %b", n, seg_n, digit_sel_n, exp_seg, exp_sel);
            end
        end
    endtask

    task automatic test_switch_latency();
        do_reset({4'h0, PATTERN});
        repeat (3) @(negedge clk);
        sw_raw = 10'h001;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            checks++;
            if (io_input_bus[0] !== (j >= 5)) begin
                errors++;
                $display("FAIL sw_latency edge k+%0d: bit0=%b, want %b", j, io_input_bus[0], (j >= 5));
            end
        end
        sw_raw = 10'h000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_glitch();
        do_reset({4'h0, PATTERN});
        btn_n_raw = 4'b1011;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 2) btn_n_raw = 4'b1111;
            checks++;
            if (io_input_bus[12] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject j=%0d: bit12=%b, want 0", j, io_input_bus[12]);
            end
        end
        btn_n_raw = 4'b1011;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 3) btn_n_raw = 4'b1111;
            checks++;
            if (io_input_bus[12] !== (j >= 5) || io_input_bus !== m_in) begin
                errors++;
                $display("FAIL btn_accept edge k+%0d: in=%h, want bit12=%b model=%h",
                         j, io_input_bus, (j >= 5), m_in);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_led();
        logic [3:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (i == 0) ? 4'hA : 4'($urandom_range(0, 15));
            io_output_bus[51:48] = v;
            @(negedge clk);
            checks++;
            if (led !== v) begin
                errors++;
                $display("FAIL led_latency i=%0d: led=%h, want %h", i, led, v);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset({4'h5, PATTERN});
        repeat (7) @(negedge clk);
        sw_raw = 10'h008;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({io_input_bus, seg_n, digit_sel_n, led} !== {14'h0000, 8'hFF, 6'b111110, 4'h0}) begin
            errors++;
            $display("FAIL mid_reset: in=%h seg=%h sel=%b led=%h, want 0000 ff 111110 0",
                     io_input_bus, seg_n, digit_sel_n, led);
        end
        reset = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            checks++;
            if (io_input_bus[3] !== (j >= 5) || {seg_n, digit_sel_n} !== {exp_seg, exp_sel}) begin
                errors++;
                $display("FAIL restart j=%0d: bit3=%b seg=%h sel=%b, want %b %h %b",
                         j, io_input_bus[3], seg_n, digit_sel_n, (j >= 5), exp_seg, exp_sel);
            end
        end
        sw_raw = 10'h000;
    endtask

    task automatic test_random();
        do_reset({4'h0, PATTERN});
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)  sw_raw = 10'($urandom());
            if ($urandom_range(0, 15) == 0) btn_n_raw = 4'($urandom());
            if ($urandom_range(0, 31) == 0) io_output_bus = 52'({$urandom(), $urandom()});
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            checks++;
            if ({io_input_bus, seg_n, digit_sel_n, led} !== {m_in, exp_seg, exp_sel, exp_led}) begin
                errors++;
                $display("FAIL random i=%0d: in=%h seg=%h sel=%b led=%h, want %h %h %b %h",
                         i, io_input_bus, seg_n, digit_sel_n, led, m_in, exp_seg, exp_sel, exp_led);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        sw_raw        = 10'h000;
        btn_n_raw     = 4'hF;
        io_output_bus = '0;
        test_reset();
        test_scan();
        test_tear_free();
        test_switch_latency();
        test_glitch();
        test_led();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_io_board_bridge
